// File: rtl/uart_feeder_pkg.sv
// Shared types and constants for the UART transmit feeder: FSM states,
// UART register offsets, the FR TX-FIFO-full bit and the CR/LF byte values.
package uart_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL,
    ST_CHECK,
    ST_WRITE,
    ST_GAP
  } feeder_state_t;

  localparam logic [31:0] FR_OFFSET   = 32'h0000_0018;
  localparam logic [31:0] DR_OFFSET   = 32'h0000_0000;
  localparam int          FR_TXFF_BIT = 5;
  localparam logic [7:0]  CR_BYTE     = 8'h0d;
  localparam logic [7:0]  LF_BYTE     = 8'h0a;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Loadable down-counter with a terminal flag, used for bus-transaction
// timeouts and for fixed idle gaps by Wishbone masters.
module wb_timeout_ctr #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Saturates at zero so the terminal flag stays up until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/uart_tx_feeder.sv
// Wishbone master that polls the UART FR and pushes bytes into DR.
// Define UART_TX_FEEDER_CRLF_EN to expand each LF byte into a CR then LF write.
module uart_tx_feeder
  import uart_feeder_pkg::*;
#(
  parameter logic [31:0] UART_BASE  = 32'h1600_0000,
  parameter int          POLL_GAP   = 8,
  parameter int          WB_TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic [31:0] o_wb_adr,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  output logic        o_busy,
  output logic        o_err,
  input  logic        i_err_clr,
  output logic [15:0] o_sent_count
);

  feeder_state_t state, next_state;
  logic       hold_full;
  logic [7:0] hold_byte;
  logic [7:0] tx_byte;
  logic       txff;
  logic       capture, stb, wr_done, err_event, hold_release;
  logic       tmo_load, tmo_expired, gap_load, gap_expired;
  logic       unused_dat;

  // Ready depends only on registered state, never on i_byte_valid.
  assign o_byte_ready = !hold_full && !i_rst;
  assign capture      = i_byte_valid && o_byte_ready;
  assign stb          = (state == ST_POLL) || (state == ST_WRITE);
  assign err_event    = stb && (i_wb_err || (tmo_expired && !i_wb_ack));
  assign wr_done      = (state == ST_WRITE) && i_wb_ack && !i_wb_err;
  assign o_busy       = hold_full || o_wb_cyc;
  assign unused_dat   = ^{i_wb_dat[31:6], i_wb_dat[4:0]};

`ifdef UART_TX_FEEDER_CRLF_EN
  logic lf_pending;
  logic cr_half;

  assign cr_half      = (hold_byte == LF_BYTE) && !lf_pending;
  assign tx_byte      = cr_half ? CR_BYTE : hold_byte;
  assign hold_release = wr_done && !cr_half;

  // Remembers that the CR half of an LF has already reached the UART.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lf_pending <= 1'b0;
    end else if (capture) begin
      lf_pending <= 1'b0;
    end else if (wr_done) begin
      lf_pending <= cr_half;
    end
  end
`else
  assign tx_byte      = hold_byte;
  assign hold_release = wr_done;
`endif

  always_comb begin
    next_state = state;
    o_wb_cyc   = 1'b0;
    o_wb_stb   = 1'b0;
    o_wb_we    = 1'b0;
    o_wb_sel   = 4'h0;
    o_wb_adr   = 32'h0;
    o_wb_dat   = 32'h0;
    case (state)
      ST_IDLE: begin
        if (hold_full) next_state = ST_POLL;
      end
      ST_POLL: begin
        o_wb_cyc = 1'b1;
        o_wb_stb = 1'b1;
        o_wb_sel = 4'hf;
        o_wb_adr = UART_BASE + FR_OFFSET;
        if (err_event)     next_state = ST_GAP;
        else if (i_wb_ack) next_state = ST_CHECK;
      end
      ST_CHECK: begin
        next_state = txff ? ST_GAP : ST_WRITE;
      end
      ST_WRITE: begin
        o_wb_cyc = 1'b1;
        o_wb_stb = 1'b1;
        o_wb_we  = 1'b1;
        o_wb_sel = 4'hf;
        o_wb_adr = UART_BASE + DR_OFFSET;
        o_wb_dat = {24'h0, tx_byte};
        if (err_event)     next_state = ST_GAP;
        else if (i_wb_ack) next_state = ST_IDLE;
      end
      ST_GAP: begin
        if (gap_expired) next_state = ST_POLL;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Counters are armed on entry so each strobe and each gap starts fresh.
  assign tmo_load = ((next_state == ST_POLL) || (next_state == ST_WRITE)) && !stb;
  assign gap_load = (next_state == ST_GAP) && (state != ST_GAP);

  wb_timeout_ctr #(.WIDTH(10)) u_bus_timeout (
    .clk        (i_clk),
    .rst        (i_rst),
    .load       (tmo_load),
    .load_value (10'(WB_TIMEOUT - 1)),
    .enable     (stb),
    .expired    (tmo_expired)
  );

  wb_timeout_ctr #(.WIDTH(8)) u_poll_gap (
    .clk        (i_clk),
    .rst        (i_rst),
    .load       (gap_load),
    .load_value (8'(POLL_GAP - 1)),
    .enable     (state == ST_GAP),
    .expired    (gap_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      hold_full    <= 1'b0;
      hold_byte    <= 8'h0;
      txff         <= 1'b0;
      o_err        <= 1'b0;
      o_sent_count <= 16'h0;
    end else begin
      state <= next_state;
      if (capture) begin
        hold_full <= 1'b1;
        hold_byte <= i_byte;
      end else if (hold_release) begin
        hold_full <= 1'b0;
      end
      if ((state == ST_POLL) && i_wb_ack && !i_wb_err) txff <= i_wb_dat[FR_TXFF_BIT];
      // A new error wins over a same-cycle clear.
      if (err_event)      o_err <= 1'b1;
      else if (i_err_clr) o_err <= 1'b0;
      if (wr_done) o_sent_count <= o_sent_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: Wishbone slave model, bus monitor
// and a queue-based model of the bytes that must reach the UART DR.
module tb_uart_tx_feeder;

  localparam logic [31:0] BASE = 32'h1600_0000;
  localparam int          GAP  = 8;
  localparam int          TMO  = 64;

  logic        clk = 1'b0;
  logic        i_rst, i_byte_valid, o_byte_ready, i_err_clr;
  logic [7:0]  i_byte;
  logic [31:0] o_wb_adr, o_wb_dat, i_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we, o_wb_cyc, o_wb_stb, i_wb_ack, i_wb_err;
  logic        o_busy, o_err;
  logic [15:0] o_sent_count;

  always #5 clk = ~clk;

  uart_tx_feeder #(.UART_BASE(BASE), .POLL_GAP(GAP), .WB_TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_byte_ready(o_byte_ready), .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel),
    .o_wb_we(o_wb_we), .o_wb_dat(o_wb_dat), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .o_busy(o_busy),
    .o_err(o_err), .i_err_clr(i_err_clr), .o_sent_count(o_sent_count)
  );

  int checks = 0;
  int passes = 0;
  int cycle  = 0;

  // Slave behaviour knobs, written only by the stimulus process.
  bit          silent    = 1'b0;
  bit          random_fr = 1'b0;
  int          full_until = 0;
  int          err_until  = 0;
  logic [31:0] default_fr = 32'h0000_0090;

  // Slave-owned transaction counters.
  int rd_seen = 0;
  int wr_seen = 0;

  // Monitor-owned observations.
  logic [31:0] got [256];
  int got_n = 0;
  int polls_done = 0;
  int poll_rise_n = 0;
  int poll_rise_cycle [256];
  int poll_gap [256];
  int write_rise_cycle = 0;
  int low_run = 0;
  int bad_bus = 0;
  bit stb_prev = 1'b0;

  // Stimulus-side model.
  logic [7:0] exp [$];
  int got_chk = 0;
  int sent_model = 0;
  int accept_cycle = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Registered-ack slave: responds one cycle after it sees a strobe.
  always @(posedge clk) begin
    if (i_rst) begin
      i_wb_ack <= 1'b0;
      i_wb_err <= 1'b0;
      i_wb_dat <= 32'h0;
    end else begin
      i_wb_ack <= 1'b0;
      i_wb_err <= 1'b0;
      if (o_wb_cyc && o_wb_stb && !i_wb_ack && !i_wb_err && !silent) begin
        i_wb_ack <= 1'b1;
        if (o_wb_we) begin
          wr_seen <= wr_seen + 1;
          if (wr_seen < err_until) i_wb_err <= 1'b1;
        end else begin
          rd_seen <= rd_seen + 1;
          if (rd_seen < full_until)                       i_wb_dat <= 32'h0000_0020;
          else if (random_fr && $urandom_range(0, 3) == 0) i_wb_dat <= $urandom | 32'h20;
          else if (random_fr)                             i_wb_dat <= $urandom & 32'hffff_ffdf;
          else                                            i_wb_dat <= default_fr;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (i_rst) begin
      stb_prev <= 1'b0;
      low_run  <= 0;
    end else begin
      stb_prev <= o_wb_stb;
      if (o_wb_stb) begin
        if (o_wb_sel != 4'hf || !o_wb_cyc ||
            o_wb_adr != (o_wb_we ? BASE : BASE + 32'h18)) bad_bus <= bad_bus + 1;
        if (!stb_prev) begin
          if (!o_wb_we) begin
            poll_rise_cycle[poll_rise_n % 256] <= cycle;
            poll_gap[poll_rise_n % 256]        <= low_run;
            poll_rise_n <= poll_rise_n + 1;
          end else begin
            write_rise_cycle <= cycle;
          end
        end
        low_run <= 0;
        if (i_wb_ack && !i_wb_err) begin
          if (o_wb_we) begin
            got[got_n % 256] <= o_wb_dat;
            got_n <= got_n + 1;
          end else begin
            polls_done <= polls_done + 1;
          end
        end
      end else begin
        low_run <= low_run + 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit track);
    int w;
    w = 0;
    @(negedge clk);
    i_byte = b;
    i_byte_valid = 1'b1;
    while (!o_byte_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    checkOutput("accept", {31'h0, o_byte_ready}, 32'h1);
    accept_cycle = cycle;
    if (track) begin
`ifdef UART_TX_FEEDER_CRLF_EN
      if (b == 8'h0a) begin
        exp.push_back(8'h0d);
        sent_model++;
      end
`endif
      exp.push_back(b);
      sent_model++;
    end
    @(posedge clk);
    #1;
    i_byte_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int w;
    w = 0;
    @(negedge clk);
    while (o_busy && w < 5000) begin
      @(negedge clk);
      w++;
    end
    checkOutput({tag, "_idle"}, {31'h0, o_busy}, 32'h0);
  endtask

  task automatic checkWrites(input string tag);
    checkOutput({tag, "_writes"}, 32'(got_n - got_chk), 32'(exp.size()));
    while (exp.size() > 0 && got_chk < got_n) begin
      checkOutput({tag, "_dat"}, got[got_chk % 256], {24'h0, exp.pop_front()});
      got_chk++;
    end
    exp.delete();
    got_chk = got_n;
    checkOutput({tag, "_count"}, {16'h0, o_sent_count}, 32'(sent_model[15:0]));
  endtask

  initial begin
    int n, p0, d0;
    i_rst = 1'b1;
    i_byte = 8'h0;
    i_byte_valid = 1'b0;
    i_err_clr = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_ready", {31'h0, o_byte_ready}, 32'h0);
    checkOutput("rst_wb", {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel}, 32'h0);
    checkOutput("rst_adr", o_wb_adr, 32'h0);
    checkOutput("rst_flags", {o_busy, o_err}, 32'h0);
    checkOutput("rst_count", {16'h0, o_sent_count}, 32'h0);
    i_rst = 1'b0;
    #1;
    checkOutput("ready_after_rst", {31'h0, o_byte_ready}, 32'h1);

    // Single byte, FIFO not full: one poll then one write at minimum latency.
    p0 = polls_done;
    applyStimulus(8'h41, 1'b1);
    waitIdle("single");
    checkWrites("single");
    checkOutput("single_polls", 32'(polls_done - p0), 32'h1);
    checkOutput("poll_latency", 32'(poll_rise_cycle[(poll_rise_n - 1) % 256] - accept_cycle), 32'd2);
    checkOutput("write_latency", 32'(write_rise_cycle - accept_cycle), 32'd5);
    checkOutput("single_ready", {31'h0, o_byte_ready}, 32'h1);

    // FIFO full on two polls: each repoll follows CHECK plus GAP idle cycles.
    default_fr = 32'h0;
    full_until = rd_seen + 2;
    p0 = poll_rise_n;
    d0 = polls_done;
    applyStimulus(8'hc3, 1'b1);
    waitIdle("full");
    checkWrites("full");
    checkOutput("full_polls", 32'(polls_done - d0), 32'd3);
    checkOutput("full_gap1", 32'(poll_gap[(p0 + 1) % 256]), 32'(GAP + 1));
    checkOutput("full_gap2", 32'(poll_gap[(p0 + 2) % 256]), 32'(GAP + 1));

    // Silent slave on a poll: strobe held exactly WB_TIMEOUT cycles.
    silent = 1'b1;
    applyStimulus(8'h7e, 1'b1);
    n = 0;
    while (!o_wb_stb && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (o_wb_stb && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tmo_len", 32'(n), 32'(TMO));
    checkOutput("tmo_err", {31'h0, o_err}, 32'h1);
    silent = 1'b0;
    waitIdle("tmo");
    checkWrites("tmo");
    checkOutput("tmo_gap", 32'(poll_gap[(poll_rise_n - 1) % 256]), 32'(GAP));
    checkOutput("tmo_sticky", {31'h0, o_err}, 32'h1);
    @(negedge clk);
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    checkOutput("err_clr", {31'h0, o_err}, 32'h0);

    // Bus error (with ack) on the DR write: retried, counted once.
    default_fr = 32'h0000_0090;
    err_until = wr_seen + 1;
    d0 = polls_done;
    applyStimulus(8'h99, 1'b1);
    waitIdle("buserr");
    checkWrites("buserr");
    checkOutput("buserr_polls", 32'(polls_done - d0), 32'd2);
    checkOutput("buserr_err", {31'h0, o_err}, 32'h1);
    @(negedge clk);
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;

    // LF byte: expanded to CR+LF only when the option is built in.
    n = sent_model;
    applyStimulus(8'h0a, 1'b1);
    waitIdle("lf");
    checkWrites("lf");
`ifdef UART_TX_FEEDER_CRLF_EN
    checkOutput("lf_delta", 32'(sent_model - n), 32'd2);
`else
    checkOutput("lf_delta", 32'(sent_model - n), 32'd1);
`endif

    // Reset while a DR write strobe is up: held byte is dropped.
    applyStimulus(8'h55, 1'b0);
    n = 0;
    while (!(o_wb_stb && o_wb_we) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrst_reach", {31'h0, o_wb_we}, 32'h1);
    d0 = got_n;
    i_rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_wb", {o_wb_cyc, o_wb_stb, o_wb_we}, 32'h0);
    checkOutput("midrst_count", {16'h0, o_sent_count}, 32'h0);
    i_rst = 1'b0;
    sent_model = 0;
    repeat (20) @(negedge clk);
    checkOutput("midrst_nowrite", 32'(got_n - d0), 32'h0);
    checkOutput("midrst_busy", {31'h0, o_busy}, 32'h0);
    got_chk = got_n;

    // Random bytes, random FR state, random producer spacing.
    random_fr = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    waitIdle("rand");
    checkWrites("rand");
    checkOutput("bus_fields", 32'(bad_bus), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
